// File: rtl/redmule_tile_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | redmule_tile_sequencer: walks the row/w-col/x-col tile loop and emits    |
// | one descriptor per step over valid/ready.            Revision: 1.0       |
// +--------------------------------------------------------------------------+
module redmule_tile_sequencer #(
  parameter int unsigned ARRAY_WIDTH  = 12,
  parameter int unsigned ARRAY_HEIGHT = 8,
  parameter int unsigned PIPE_REGS    = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        cfg_valid_i,
  input  logic [15:0] x_rows_iter_i,
  input  logic [15:0] x_cols_iter_i,
  input  logic [15:0] w_cols_iter_i,
  input  logic [7:0]  x_rows_lftovr_i,
  input  logic [7:0]  x_cols_lftovr_i,
  input  logic [7:0]  w_cols_lftovr_i,
  output logic        tile_valid_o,
  input  logic        tile_ready_i,
  output logic [15:0] row_idx_o,
  output logic [15:0] wcol_idx_o,
  output logic [15:0] xcol_idx_o,
  output logic [7:0]  rows_eff_o,
  output logic [7:0]  xcols_eff_o,
  output logic [7:0]  wcols_eff_o,
  output logic        first_acc_o,
  output logic        store_o,
  output logic [15:0] store_cnt_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned C_TILE      = ARRAY_HEIGHT * (PIPE_REGS + 1);
  localparam logic [7:0]  C_ROWS_FULL = 8'(ARRAY_WIDTH);
  localparam logic [7:0]  C_COLS_FULL = 8'(C_TILE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      r_state, w_state_nxt;
  logic [15:0] r_x_rows_iter, r_x_cols_iter, r_w_cols_iter;
  logic [7:0]  r_x_rows_lftovr, r_x_cols_lftovr, r_w_cols_lftovr;
  logic [15:0] r_row_idx, r_wcol_idx, r_xcol_idx, r_store_cnt;
  logic        r_done;
  logic        w_capture, w_enter_done, w_hs, w_zero_cfg, w_active;
  logic        w_row_last, w_wcol_last, w_xcol_last, w_final;

  assign w_zero_cfg  = (x_rows_iter_i == 16'd0) || (x_cols_iter_i == 16'd0) ||
                       (w_cols_iter_i == 16'd0);
  assign w_row_last  = (r_row_idx  == r_x_rows_iter - 16'd1);
  assign w_wcol_last = (r_wcol_idx == r_w_cols_iter - 16'd1);
  assign w_xcol_last = (r_xcol_idx == r_x_cols_iter - 16'd1);
  assign w_final     = w_row_last && w_wcol_last && w_xcol_last;
  assign w_hs        = (r_state == RUN) && tile_ready_i;

  always_comb begin
    w_state_nxt  = r_state;
    w_capture    = 1'b0;
    w_enter_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_valid_i) begin
          w_capture = 1'b1;
          if (w_zero_cfg) begin
            w_state_nxt  = DONE;
            w_enter_done = 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (w_hs && w_final) begin
          w_state_nxt  = DONE;
          w_enter_done = 1'b1;
        end
      end
      DONE: begin
        // Wait for the tiler valid to drop so one level-high valid runs one job.
        if (!cfg_valid_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else if (clear_i) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_enter_done;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_x_rows_iter   <= '0;
      r_x_cols_iter   <= '0;
      r_w_cols_iter   <= '0;
      r_x_rows_lftovr <= '0;
      r_x_cols_lftovr <= '0;
      r_w_cols_lftovr <= '0;
      r_row_idx       <= '0;
      r_wcol_idx      <= '0;
      r_xcol_idx      <= '0;
      r_store_cnt     <= '0;
    end else if (clear_i) begin
      r_row_idx   <= '0;
      r_wcol_idx  <= '0;
      r_xcol_idx  <= '0;
      r_store_cnt <= '0;
    end else if (w_capture) begin
      r_x_rows_iter   <= x_rows_iter_i;
      r_x_cols_iter   <= x_cols_iter_i;
      r_w_cols_iter   <= w_cols_iter_i;
      r_x_rows_lftovr <= x_rows_lftovr_i;
      r_x_cols_lftovr <= x_cols_lftovr_i;
      r_w_cols_lftovr <= w_cols_lftovr_i;
      r_row_idx       <= '0;
      r_wcol_idx      <= '0;
      r_xcol_idx      <= '0;
      r_store_cnt     <= '0;
    end else if (w_hs) begin
      if (w_xcol_last) r_store_cnt <= r_store_cnt + 16'd1;
      // Indices freeze on the final tile so DONE still shows the last descriptor.
      if (!w_final) begin
        if (w_xcol_last) begin
          r_xcol_idx <= '0;
          if (w_wcol_last) begin
            r_wcol_idx <= '0;
            r_row_idx  <= r_row_idx + 16'd1;
          end else begin
            r_wcol_idx <= r_wcol_idx + 16'd1;
          end
        end else begin
          r_xcol_idx <= r_xcol_idx + 16'd1;
        end
      end
    end
  end

  assign w_active     = (r_state != IDLE);
  assign tile_valid_o = (r_state == RUN);
  assign busy_o       = (r_state == RUN);
  assign done_o       = r_done;
  assign row_idx_o    = r_row_idx;
  assign wcol_idx_o   = r_wcol_idx;
  assign xcol_idx_o   = r_xcol_idx;
  assign store_cnt_o  = r_store_cnt;
  assign first_acc_o  = w_active && (r_xcol_idx == 16'd0);
  assign store_o      = w_active && w_xcol_last;
  assign rows_eff_o   = !w_active ? 8'd0 :
                        (w_row_last && r_x_rows_lftovr != 8'd0) ? r_x_rows_lftovr : C_ROWS_FULL;
  assign xcols_eff_o  = !w_active ? 8'd0 :
                        (w_xcol_last && r_x_cols_lftovr != 8'd0) ? r_x_cols_lftovr : C_COLS_FULL;
  assign wcols_eff_o  = !w_active ? 8'd0 :
                        (w_wcol_last && r_w_cols_lftovr != 8'd0) ? r_w_cols_lftovr : C_COLS_FULL;

endmodule
`default_nettype wire

// File: tb/tb_redmule_tile_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_redmule_tile_sequencer: scoreboard bench for the tile sequencer.      |
// |                                                       Revision: 1.0      |
// +--------------------------------------------------------------------------+
module tb_redmule_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear, cfg_valid, tile_ready;
  logic [15:0] x_rows_iter, x_cols_iter, w_cols_iter;
  logic [7:0]  x_rows_lftovr, x_cols_lftovr, w_cols_lftovr;
  logic        tile_valid, first_acc, store, busy, done;
  logic [15:0] row_idx, wcol_idx, xcol_idx, store_cnt;
  logic [7:0]  rows_eff, xcols_eff, wcols_eff;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [89:0] exp_q[$];

  redmule_tile_sequencer dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .cfg_valid_i(cfg_valid),
    .x_rows_iter_i(x_rows_iter), .x_cols_iter_i(x_cols_iter), .w_cols_iter_i(w_cols_iter),
    .x_rows_lftovr_i(x_rows_lftovr), .x_cols_lftovr_i(x_cols_lftovr),
    .w_cols_lftovr_i(w_cols_lftovr), .tile_valid_o(tile_valid), .tile_ready_i(tile_ready),
    .row_idx_o(row_idx), .wcol_idx_o(wcol_idx), .xcol_idx_o(xcol_idx),
    .rows_eff_o(rows_eff), .xcols_eff_o(xcols_eff), .wcols_eff_o(wcols_eff),
    .first_acc_o(first_acc), .store_o(store), .store_cnt_o(store_cnt),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [89:0] cur_desc();
    return {row_idx, wcol_idx, xcol_idx, rows_eff, xcols_eff, wcols_eff,
            first_acc, store, store_cnt};
  endfunction

  function automatic logic [92:0] all_outs();
    return {cur_desc(), tile_valid, busy, done};
  endfunction

  task automatic push_tile(input int r, w, x, re, xe, we, f, s, c);
    exp_q.push_back({16'(r), 16'(w), 16'(x), 8'(re), 8'(xe), 8'(we), 1'(f), 1'(s), 16'(c)});
  endtask

  task automatic push_basic();
    push_tile(0, 0, 0, 12, 32, 32, 1, 0, 0);
    push_tile(0, 0, 1, 12, 32, 32, 0, 1, 0);
    push_tile(1, 0, 0, 12, 32, 32, 1, 0, 1);
    push_tile(1, 0, 1, 12, 32, 32, 0, 1, 1);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    logic        stall;
    logic [89:0] held, act;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (rst_ni && tile_valid) begin
        act = cur_desc();
        if (stall) check("stall_stable", act, held);
        if (tile_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_tile: got %0h, expected none", act);
          end else begin
            check("tile", act, exp_q.pop_front());
          end
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          held  = act;
        end
      end else begin
        stall = 1'b0;
      end
    end
  end

  task automatic drive_cfg(input logic [15:0] xr, xc, wc, input logic [7:0] lr, lc, lw);
    x_rows_iter   = xr;
    x_cols_iter   = xc;
    w_cols_iter   = wc;
    x_rows_lftovr = lr;
    x_cols_lftovr = lc;
    w_cols_lftovr = lw;
  endtask

  task automatic run_job(input logic [15:0] xr, xc, wc, input logic [7:0] lr, lc, lw,
                         input bit bp, input logic [15:0] exp_stores);
    bit zero, done_seen;
    int cyc;
    zero = (xr == 0) || (xc == 0) || (wc == 0);
    @(posedge clk); #1;
    drive_cfg(xr, xc, wc, lr, lc, lw);
    cfg_valid  = 1'b1;
    tile_ready = 1'b0;
    @(posedge clk); #1;
    drive_cfg(16'd9, 16'd9, 16'd9, 8'd5, 8'd5, 8'd5);
    cyc        = 0;
    tile_ready = 1'b1;
    @(negedge clk);
    if (zero) check("zero_done_latency", done, 1);
    else      check("valid_latency", tile_valid, 1);
    done_seen = done;
    while (!done_seen && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      tile_ready = bp ? (cyc % 3 == 0) : 1'b1;
      @(negedge clk);
      done_seen = done;
    end
    check("done_seen", done_seen, 1);
    check("done_valid_low", {tile_valid, busy}, 0);
    check("store_cnt", store_cnt, exp_stores);
    if (!zero) check("final_idx", {row_idx, wcol_idx, xcol_idx}, {xr - 16'd1, wc - 16'd1, xc - 16'd1});
    check("queue_drained", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_retrigger", {done, tile_valid}, 0);
    end
    @(posedge clk); #1;
    cfg_valid  = 1'b0;
    tile_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    clear      = 1'b0;
    cfg_valid  = 1'b0;
    tile_ready = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 0);
    rst_ni = 1'b1;

    push_basic();
    run_job(2, 2, 1, 0, 0, 0, 0, 2);

    push_tile(0, 0, 0, 12, 32, 32, 1, 0, 0);
    push_tile(0, 0, 1, 12,  8, 32, 0, 1, 0);
    push_tile(0, 1, 0, 12, 32,  1, 1, 0, 1);
    push_tile(0, 1, 1, 12,  8,  1, 0, 1, 1);
    push_tile(1, 0, 0,  1, 32, 32, 1, 0, 2);
    push_tile(1, 0, 1,  1,  8, 32, 0, 1, 2);
    push_tile(1, 1, 0,  1, 32,  1, 1, 0, 3);
    push_tile(1, 1, 1,  1,  8,  1, 0, 1, 3);
    run_job(2, 2, 2, 1, 8, 1, 0, 4);

    push_basic();
    run_job(2, 2, 1, 0, 0, 0, 1, 2);

    push_tile(0, 0, 0, 12, 32, 32, 1, 1, 0);
    push_tile(0, 1, 0, 12, 32, 32, 1, 1, 1);
    push_tile(0, 2, 0, 12, 32,  5, 1, 1, 2);
    run_job(1, 1, 3, 0, 0, 5, 0, 3);

    run_job(1, 1, 0, 0, 0, 0, 0, 0);
    run_job(1, 1, 0, 0, 0, 0, 0, 0);

    // Abort after the second handshake.
    push_tile(0, 0, 0, 12, 32, 32, 1, 0, 0);
    push_tile(0, 0, 1, 12, 32, 32, 0, 1, 0);
    @(posedge clk); #1;
    drive_cfg(2, 2, 1, 0, 0, 0);
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    tile_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    tile_ready = 1'b0;
    clear      = 1'b1;
    cfg_valid  = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("abort_outputs", all_outs(), 0);
    check("abort_queue", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", {done, tile_valid}, 0);
    end

    push_basic();
    run_job(2, 2, 1, 0, 0, 0, 0, 2);

    // Asynchronous reset while a tile is stalled.
    @(posedge clk); #1;
    drive_cfg(2, 2, 1, 0, 0, 0);
    cfg_valid = 1'b1;
    @(posedge clk); #3;
    check("pre_reset_valid", {tile_valid, busy}, 2'b11);
    rst_ni = 1'b0;
    #1;
    check("async_reset", {tile_valid, busy, done}, 0);
    cfg_valid = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    check("post_reset_idle", all_outs(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
